// File: rtl/branch_tracker_pkg.sv
// Shared types and constants for the branch tracker slice.
// The tracker top, its FIFO and the bench all import this package.
// The optional statistics outputs use STAT_W and sat_inc; they exist
// only when BRANCH_TRACKER_STATS_EN is defined.
package branch_tracker_pkg;

    // Address width used for PCs and targets
    localparam int ADDR_W = 32;
    typedef logic [ADDR_W-1:0] addr_t;

    // Width of the optional statistics counters
    localparam int STAT_W = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Tracker FSM: IDLE accepts a new branch; WAIT_PRED waits for the predictor answer
    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_PRED = 1'b1
    } state_t;

    // One in-flight branch: its PC, taken target and the direction we steered fetch to
    typedef struct packed {
        addr_t pc;
        addr_t target;
        logic  pred;
    } fifo_entry_t;

    // Fall-through PC of a branch (wraps modulo 2^32)
    function automatic addr_t seq_pc(input addr_t pc);
        return pc + addr_t'(4);
    endfunction

    // Saturating increment for the statistics counters
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        if (v == {STAT_W{1'b1}}) begin
            return v;
        end
        return v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/branch_tracker_fifo.sv
// branch_fifo: DEPTH-entry in-order FIFO of in-flight branches.
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.
// flush empties the FIFO and takes priority over push and pop in the same
// cycle. head is only meaningful while empty is low.
module branch_fifo
    import branch_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  fifo_entry_t             push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output fifo_entry_t             head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Overflow/underflow protection: a push into a full FIFO or a pop of an
    // empty one is dropped rather than corrupting the pointers.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/branch_tracker.sv
// branch_tracker: instruction-queue-side companion of the 2-bit predictor.
// Requests a prediction per decoded conditional branch, steers fetch to the
// predicted PC, keeps in-flight branches in order, and on resolution sends
// the counter update and, on mispredict, the pipeline clear + restart PC.
//
// Optional feature: define BRANCH_TRACKER_STATS_EN to add the saturating
// branch_count_out / mispredict_count_out statistics outputs.
//
// Handshake: a decoded branch transfers on a rising clk edge where
// br_valid_in && br_ready_out && rdy. br_ready_out depends only on registered
// state (FSM in IDLE, FIFO not full, no clear pulse in progress), never on
// br_valid_in. pred_valid_in, res_valid_in are single-cycle strobes with no
// back-pressure; they are acted on only while rdy is high. All outputs are
// registered; pred_req_out, fetch_redirect_out, upd_en_out and clear_flag_out
// are single-cycle pulses, forced low in any cycle following rdy low.
//
// state_dbg_out and fifo_count_dbg_out expose the FSM state and occupancy.
module branch_tracker
    import branch_tracker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              br_valid_in,
    input  logic [ADDR_W-1:0] br_pc_in,
    input  logic [ADDR_W-1:0] br_target_in,
    output logic              br_ready_out,
    output logic              pred_req_out,
    input  logic              pred_valid_in,
    input  logic              pred_taken_in,
    output logic              fetch_redirect_out,
    output logic [ADDR_W-1:0] fetch_pc_out,
    input  logic              res_valid_in,
    input  logic              res_taken_in,
    output logic              upd_en_out,
    output logic              upd_taken_out,
    output logic              clear_flag_out,
    output logic [ADDR_W-1:0] clear_pc_out,
`ifdef BRANCH_TRACKER_STATS_EN
    output logic [STAT_W-1:0] branch_count_out,
    output logic [STAT_W-1:0] mispredict_count_out,
`endif
    output state_t            state_dbg_out,
    output logic [4:0]        fifo_count_dbg_out
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t           state;
    state_t           state_next;
    fifo_entry_t      head;
    fifo_entry_t      push_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    addr_t            pend_pc;
    addr_t            pend_target;
    logic             resolve;
    logic             mispredict;
    logic             accept;
    logic             pred_done;

    // A resolve against an empty FIFO is meaningless and is ignored outright.
    assign resolve    = rdy && res_valid_in && !fifo_empty;
    assign mispredict = resolve && (res_taken_in != head.pred);

    // A mispredict squashes everything younger than the resolving branch,
    // including a branch being accepted or a prediction arriving this cycle.
    assign br_ready_out = (state == IDLE) && !fifo_full && !clear_flag_out;
    assign accept       = rdy && br_valid_in && br_ready_out && !mispredict;
    assign pred_done    = rdy && (state == WAIT_PRED) && pred_valid_in && !mispredict;

    assign push_entry = '{pc: pend_pc, target: pend_target, pred: pred_taken_in};

    assign state_dbg_out      = state;
    assign fifo_count_dbg_out = 5'(fifo_count);

    branch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pred_done),
        .push_data (push_entry),
        .pop       (resolve),
        .flush     (mispredict),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head),
        .count     (fifo_count)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: one outstanding prediction at a time, mispredict forces IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT_PRED;
                end
            end
            WAIT_PRED: begin
                if (pred_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (mispredict) begin
            state_next = IDLE;
        end
    end

    // Branch awaiting its prediction: captured at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_pc     <= '0;
            pend_target <= '0;
        end else if (accept) begin
            pend_pc     <= br_pc_in;
            pend_target <= br_target_in;
        end
    end

    // Registered outputs: pulses last one cycle, data outputs hold between events
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_req_out       <= FALSE;
            fetch_redirect_out <= FALSE;
            fetch_pc_out       <= '0;
            upd_en_out         <= FALSE;
            upd_taken_out      <= FALSE;
            clear_flag_out     <= FALSE;
            clear_pc_out       <= '0;
        end else begin
            pred_req_out       <= accept;
            fetch_redirect_out <= pred_done;
            upd_en_out         <= resolve;
            clear_flag_out     <= mispredict;
            if (pred_done) begin
                fetch_pc_out <= (pred_taken_in == TRUE) ? pend_target : seq_pc(pend_pc);
            end
            if (resolve) begin
                upd_taken_out <= res_taken_in;
            end
            if (mispredict) begin
                clear_pc_out <= (res_taken_in == TRUE) ? head.target : seq_pc(head.pc);
            end
        end
    end

`ifdef BRANCH_TRACKER_STATS_EN
    // Resolve and mispredict statistics, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_out     <= '0;
            mispredict_count_out <= '0;
        end else begin
            if (resolve) begin
                branch_count_out <= sat_inc(branch_count_out);
            end
            if (mispredict) begin
                mispredict_count_out <= sat_inc(mispredict_count_out);
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_tracker.sv
// Testbench for branch_tracker: directed scenarios followed by random
// stimulus, all checked every cycle against a queue-based reference model.
// Build with BRANCH_TRACKER_STATS_EN defined to also check the counters.
module tb_branch_tracker;
    import branch_tracker_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        br_valid_in = 1'b0;
    logic [31:0] br_pc_in = '0;
    logic [31:0] br_target_in = '0;
    logic        pred_valid_in = 1'b0;
    logic        pred_taken_in = 1'b0;
    logic        res_valid_in = 1'b0;
    logic        res_taken_in = 1'b0;

    logic        br_ready_out;
    logic        pred_req_out;
    logic        fetch_redirect_out;
    logic [31:0] fetch_pc_out;
    logic        upd_en_out;
    logic        upd_taken_out;
    logic        clear_flag_out;
    logic [31:0] clear_pc_out;
    state_t      state_dbg_out;
    logic [4:0]  fifo_count_dbg_out;
`ifdef BRANCH_TRACKER_STATS_EN
    logic [31:0] branch_count_out;
    logic [31:0] mispredict_count_out;
`endif

    always #5 clk = ~clk;

    branch_tracker #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .br_valid_in        (br_valid_in),
        .br_pc_in           (br_pc_in),
        .br_target_in       (br_target_in),
        .br_ready_out       (br_ready_out),
        .pred_req_out       (pred_req_out),
        .pred_valid_in      (pred_valid_in),
        .pred_taken_in      (pred_taken_in),
        .fetch_redirect_out (fetch_redirect_out),
        .fetch_pc_out       (fetch_pc_out),
        .res_valid_in       (res_valid_in),
        .res_taken_in       (res_taken_in),
        .upd_en_out         (upd_en_out),
        .upd_taken_out      (upd_taken_out),
        .clear_flag_out     (clear_flag_out),
        .clear_pc_out       (clear_pc_out),
`ifdef BRANCH_TRACKER_STATS_EN
        .branch_count_out     (branch_count_out),
        .mispredict_count_out (mispredict_count_out),
`endif
        .state_dbg_out      (state_dbg_out),
        .fifo_count_dbg_out (fifo_count_dbg_out)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
    } ref_br_t;

    ref_br_t     m_q[$];               // in-flight branches, oldest first
    logic [31:0] exp_q[$];             // expected fetch redirect PCs
    bit          m_wait = 0;           // a branch is waiting for its prediction
    logic [31:0] m_pend_pc = '0;
    logic [31:0] m_pend_tgt = '0;
    logic        e_req = 0, e_redir = 0, e_upd_en = 0, e_upd_taken = 0, e_clear = 0;
    logic [31:0] e_fetch_pc = '0, e_clear_pc = '0;
    logic [31:0] e_br_cnt = '0, e_mis_cnt = '0;

    function automatic logic exp_ready();
        return !m_wait && (m_q.size() < DEPTH) && !e_clear;
    endfunction

    // Apply one clock edge worth of the tracker rules to the model
    task automatic model_step();
        bit      ready_now;
        bit      res;
        bit      mis;
        bit      acc;
        bit      done;
        ref_br_t head;
        ref_br_t nb;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_wait = 0;
            m_pend_pc = '0;
            m_pend_tgt = '0;
            e_req = 0; e_redir = 0; e_upd_en = 0; e_upd_taken = 0; e_clear = 0;
            e_fetch_pc = '0; e_clear_pc = '0;
            e_br_cnt = '0; e_mis_cnt = '0;
        end else if (!rdy) begin
            e_req = 0; e_redir = 0; e_upd_en = 0; e_clear = 0;
        end else begin
            ready_now = exp_ready();
            res = res_valid_in && (m_q.size() != 0);
            mis = 0;
            if (res) begin
                head = m_q.pop_front();
                mis = (res_taken_in != head.pred);
            end
            acc = br_valid_in && ready_now && !mis;
            done = m_wait && pred_valid_in && !mis;

            e_upd_en = res;
            if (res) e_upd_taken = res_taken_in;
            e_clear = mis;
            if (mis) begin
                e_clear_pc = res_taken_in ? head.target : head.pc + 32'd4;
                m_q.delete();
                m_wait = 0;
            end
            e_redir = done;
            if (done) begin
                e_fetch_pc = pred_taken_in ? m_pend_tgt : m_pend_pc + 32'd4;
                nb.pc = m_pend_pc;
                nb.target = m_pend_tgt;
                nb.pred = pred_taken_in;
                m_q.push_back(nb);
                exp_q.push_back(e_fetch_pc);
                m_wait = 0;
            end
            e_req = acc;
            if (acc) begin
                m_wait = 1;
                m_pend_pc = br_pc_in;
                m_pend_tgt = br_target_in;
            end
            if (res && e_br_cnt != 32'hFFFF_FFFF) e_br_cnt++;
            if (mis && e_mis_cnt != 32'hFFFF_FFFF) e_mis_cnt++;
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_pc;
        check("br_ready", 32'(br_ready_out), 32'(exp_ready()));
        check("pred_req", 32'(pred_req_out), 32'(e_req));
        check("fetch_redirect", 32'(fetch_redirect_out), 32'(e_redir));
        check("fetch_pc", fetch_pc_out, e_fetch_pc);
        check("upd_en", 32'(upd_en_out), 32'(e_upd_en));
        check("upd_taken", 32'(upd_taken_out), 32'(e_upd_taken));
        check("clear_flag", 32'(clear_flag_out), 32'(e_clear));
        check("clear_pc", clear_pc_out, e_clear_pc);
        check("state", 32'(state_dbg_out), m_wait ? 32'(WAIT_PRED) : 32'(IDLE));
        check("fifo_count", 32'(fifo_count_dbg_out), 32'(m_q.size()));
`ifdef BRANCH_TRACKER_STATS_EN
        check("branch_count", branch_count_out, e_br_cnt);
        check("mispredict_count", mispredict_count_out, e_mis_cnt);
`endif
        if (fetch_redirect_out === 1'b1) begin
            check("redirect_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check("redirect_pc", fetch_pc_out, exp_pc);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        rdy = 1'b1;
        br_valid_in = 1'b0;
        pred_valid_in = 1'b0;
        pred_taken_in = 1'b0;
        res_valid_in = 1'b0;
        res_taken_in = 1'b0;
    endtask

    // Accept a branch, wait out the predictor latency, answer with 'taken'
    task automatic send_branch(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        br_valid_in = 1'b1;
        br_pc_in = pc;
        br_target_in = tgt;
        tick();
        br_valid_in = 1'b0;
        tick();
        pred_valid_in = 1'b1;
        pred_taken_in = taken;
        tick();
        pred_valid_in = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        res_valid_in = 1'b1;
        res_taken_in = taken;
        tick();
        res_valid_in = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] saved_br_cnt;
        logic [31:0] saved_mis_cnt;

        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        check("reset_fetch_pc", fetch_pc_out, 32'h0);
        check("reset_clear_pc", clear_pc_out, 32'h0);
        check("reset_br_ready", 32'(br_ready_out), 32'd1);
        rst = 1'b0;
        tick();

        // Predicted taken, resolved taken
        send_branch(32'h100, 32'h200, 1'b1);
        check("s1_redirect", 32'(fetch_redirect_out), 32'd1);
        check("s1_fetch_pc", fetch_pc_out, 32'h200);
        resolve(1'b1);
        check("s1_upd_en", 32'(upd_en_out), 32'd1);
        check("s1_upd_taken", 32'(upd_taken_out), 32'd1);
        check("s1_no_clear", 32'(clear_flag_out), 32'd0);
        tick();

        // Predicted not-taken, resolved taken: mispredict
        send_branch(32'h100, 32'h200, 1'b0);
        check("s2_fetch_pc", fetch_pc_out, 32'h104);
        resolve(1'b1);
        check("s2_clear", 32'(clear_flag_out), 32'd1);
        check("s2_clear_pc", clear_pc_out, 32'h200);
        check("s2_fifo_empty", 32'(fifo_count_dbg_out), 32'd0);
        tick();
        check("s2_ready_after", 32'(br_ready_out), 32'd1);

        // Fill the FIFO, then free one slot with a correct resolve
        for (int i = 0; i < DEPTH; i++) begin
            send_branch(32'h1000 + 32'(16 * i), 32'h2000 + 32'(16 * i), 1'((i % 2) == 1));
        end
        check("s3_full_not_ready", 32'(br_ready_out), 32'd0);
        resolve(1'b0);
        check("s3_ready_again", 32'(br_ready_out), 32'd1);
        check("s3_no_clear", 32'(clear_flag_out), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            resolve(1'((i % 2) == 1));
        end
        tick();

        // Mispredict in the same cycle as a new branch's prediction
        send_branch(32'h300, 32'h400, 1'b0);
        br_valid_in = 1'b1;
        br_pc_in = 32'h500;
        br_target_in = 32'h580;
        tick();
        br_valid_in = 1'b0;
        tick();
        pred_valid_in = 1'b1;
        pred_taken_in = 1'b1;
        res_valid_in = 1'b1;
        res_taken_in = 1'b1;
        tick();
        idle_inputs();
        check("s4_no_redirect", 32'(fetch_redirect_out), 32'd0);
        check("s4_clear_pc", clear_pc_out, 32'h400);
        check("s4_fifo_empty", 32'(fifo_count_dbg_out), 32'd0);
        check("s4_state_idle", 32'(state_dbg_out), 32'(IDLE));
        tick();

        // rdy low for three cycles while waiting for the prediction
        br_valid_in = 1'b1;
        br_pc_in = 32'h600;
        br_target_in = 32'h700;
        tick();
        br_valid_in = 1'b0;
        rdy = 1'b0;
        pred_valid_in = 1'b1;
        pred_taken_in = 1'b1;
        repeat (3) begin
            tick();
            check("s5_no_req", 32'(pred_req_out), 32'd0);
            check("s5_no_redirect", 32'(fetch_redirect_out), 32'd0);
            check("s5_state_held", 32'(state_dbg_out), 32'(WAIT_PRED));
        end
        rdy = 1'b1;
        tick();
        pred_valid_in = 1'b0;
        check("s5_redirect", 32'(fetch_redirect_out), 32'd1);
        check("s5_fetch_pc", fetch_pc_out, 32'h700);
        resolve(1'b1);
        tick();

        // Resolve with an empty FIFO is ignored
        saved_br_cnt = e_br_cnt;
        saved_mis_cnt = e_mis_cnt;
        resolve(1'b0);
        check("s6_no_upd", 32'(upd_en_out), 32'd0);
        check("s6_no_clear", 32'(clear_flag_out), 32'd0);
`ifdef BRANCH_TRACKER_STATS_EN
        check("s6_branch_count", branch_count_out, saved_br_cnt);
        check("s6_mispredict_count", mispredict_count_out, saved_mis_cnt);
`endif
        tick();

        // Random traffic, including rdy stalls, 32-bit PC wrap and mid-run resets
        repeat (3000) begin
            rdy = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            br_valid_in = 1'($urandom_range(0, 1));
            br_pc_in = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            br_target_in = $urandom() & 32'hFFFF_FFFC;
            pred_valid_in = ($urandom_range(0, 2) == 0);
            pred_taken_in = 1'($urandom_range(0, 1));
            res_valid_in = ($urandom_range(0, 3) == 0);
            res_taken_in = 1'($urandom_range(0, 1));
            tick();
        end

        idle_inputs();
        repeat (4) tick();
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_tracker.md
# branch_tracker

Instruction-queue-side companion of the 2-bit branch predictor. Issues one prediction request per decoded conditional branch, steers fetch to the predicted PC, and holds in-flight branches in an in-order FIFO. When the ALU resolves each branch, it sends the counter update to the predictor and, on mispredict, raises the pipeline clear with the corrected PC.

## Interface
- DEPTH, 4: in-flight branch FIFO entries, power of two, 2..16.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state
- br_valid_in  in  1  decode presents a conditional branch
- br_pc_in  in  32  branch PC
- br_target_in  in  32  taken target
- br_ready_out  out  1  tracker accepts a branch this cycle
- pred_req_out  out  1  to predictor predict-enable
- pred_valid_in  in  1  predictor result valid
- pred_taken_in  in  1  predictor result (1 = taken)
- fetch_redirect_out  out  1  one-cycle fetch steer pulse
- fetch_pc_out  out  32  predicted next PC
- res_valid_in  in  1  ALU resolved oldest branch
- res_taken_in  in  1  actual outcome
- upd_en_out  out  1  to predictor update-enable
- upd_taken_out  out  1  to predictor update-result
- clear_flag_out  out  1  mispredict flush pulse
- clear_pc_out  out  32  correct restart PC

## Operation
- FSM states: IDLE, WAIT_PRED.
- br_ready_out = (state==IDLE) && !full && !clear_flag_out.
- IDLE: on br_valid_in && br_ready_out, latch pc/target, pulse pred_req_out for 1 cycle, go WAIT_PRED.
- WAIT_PRED: on pred_valid_in, push {pc, target, pred_taken_in}; pulse fetch_redirect_out with fetch_pc_out = pred ? target : pc+4 (32-bit wrap); go IDLE. No timeout.
- Resolve: res_valid_in pops head. Pulse upd_en_out, upd_taken_out = res_taken_in.
- If res_taken_in != head.pred: pulse clear_flag_out, clear_pc_out = res_taken_in ? head.target : head.pc+4; flush FIFO; force IDLE; drop any same-cycle pred_valid_in and suppress fetch_redirect_out.
- res_valid_in with FIFO empty: ignored, no update, no clear.
- Push and correct pop in same cycle: both performed, count unchanged.
- Full: br_ready_out low; pending WAIT_PRED push never occurs when full (acceptance requires !full).

## Timing
- All outputs registered. Reset values: every output 0; FIFO empty; state IDLE.
- pred_req_out asserted cycle after acceptance; predictor returns 1 cycle later; fetch_redirect_out cycle after pred_valid_in.
- upd_en_out and clear_flag_out asserted cycle after res_valid_in; single-cycle pulses.
- rdy low: state, FIFO and counters hold; pulse outputs driven 0; inputs ignored.
- rst mid-operation: discards all in-flight entries within the cycle.

## Configuration
- BRANCH_TRACKER_STATS_EN defined: adds outputs branch_count_out (32) and mispredict_count_out (32), saturating at 0xFFFFFFFF, incremented on each non-ignored resolve and each mispredict; reset 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: AddrType width (32), True/False constants, FSM state encoding, FIFO entry typedef {pc, target, pred}.
- One sub-module: branch_fifo (DEPTH-entry synchronous FIFO with push, pop, flush, full, empty, head).

## Test plan
- Branch pc=0x100, target=0x200, predictor taken -> fetch_pc_out=0x200; resolve taken -> upd_en_out=1, upd_taken_out=1, no clear.
- Same branch predicted not-taken -> fetch_pc_out=0x104; resolve taken -> clear_flag_out=1, clear_pc_out=0x200, FIFO empty, br_ready_out=1 next cycle.
- Four branches accepted without resolve (DEPTH=4) -> br_ready_out=0; one correct resolve -> br_ready_out=1.
- Mispredict in same cycle as pred_valid_in of new branch -> no fetch_redirect_out, FIFO empty, state IDLE.
- rdy=0 for 3 cycles during WAIT_PRED -> no outputs pulse, state held; rdy=1 then pred_valid_in -> normal redirect.
- res_valid_in on empty FIFO -> upd_en_out=0, clear_flag_out=0; with STATS_EN, counters unchanged.
